// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: decode redirect, IF/ID handshake and instruction-memory port.
// master = prefetch queue, slave = surrounding pipeline/memory.
interface fetch_prefetch_queue_if #(
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned INST_WIDTH = 19
);
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirectPc;
    logic                  take;
    logic                  imReq;
    logic [PC_WIDTH-1:0]   imAddr;
    logic                  imValid;
    logic [INST_WIDTH-1:0] imData;
    logic                  instValid;
    logic [INST_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]   pcOut;

    modport master (
        input  redirect, redirectPc, take, imValid, imData,
        output imReq, imAddr, instValid, instruction, pcOut
    );

    modport slave (
        output redirect, redirectPc, take, imValid, imData,
        input  imReq, imAddr, instValid, instruction, pcOut
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues in-order memory requests, queues responses with
// their return PC, presents the head to IF/ID and flushes on a control-flow redirect.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned INST_WIDTH = 19
) (
    input logic                   clk,
    input logic                   rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DepthW = DEPTH[CW:0];

    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [INST_WIDTH-1:0] data_q [DEPTH];
    // Entries hold PC + 1 so pcOut is a plain read and reads 0 out of reset.
    logic [PC_WIDTH-1:0]   ret_q  [DEPTH];

    logic          issue, push, pop;
    logic [CW:0]   occupancy;

    always_comb begin
        occupancy = {1'b0, count_q} + {1'b0, outst_q};
        issue     = ~rst & ~bus.redirect & (occupancy < DepthW);
        push      = bus.imValid & ~bus.redirect & (drop_q == '0);
        pop       = bus.take & (count_q != '0) & ~bus.redirect;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        outst_d    = outst_q + CW'(issue) - CW'(bus.imValid);
        drop_d     = drop_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        if (issue) fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
        if (push)  resp_pc_d  = resp_pc_q + PC_WIDTH'(1);
        if (bus.imValid && !bus.redirect && drop_q != '0) drop_d = drop_q - CW'(1);

        if (bus.redirect) begin
            // Every request still in flight (already-stale ones included) becomes stale.
            drop_d     = outst_q - CW'(bus.imValid);
            fetch_pc_d = bus.redirectPc;
            resp_pc_d  = bus.redirectPc;
            count_d    = '0;
            wr_ptr_d   = rd_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                ret_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= bus.imData;
                ret_q[wr_ptr_q]  <= resp_pc_q + PC_WIDTH'(1);
            end
        end
    end

    assign bus.imReq       = issue;
    assign bus.imAddr      = fetch_pc_q;
    assign bus.instValid   = (count_q != '0);
    assign bus.instruction = data_q[rd_ptr_q];
    assign bus.pcOut       = ret_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised bench for fetch_prefetch_queue: an in-order variable-latency memory and a
// generation-tagged reference model of the fetch stream.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    typedef struct { logic [11:0] addr; int ready; } mem_req_t;
    typedef struct { logic [11:0] addr; int gen; }   ref_req_t;
    typedef struct { logic [11:0] pc1; logic [18:0] data; } ref_ent_t;

    logic clk = 1'b0;
    logic rst;
    fetch_prefetch_queue_if #(.PC_WIDTH(12), .INST_WIDTH(19)) bus_if ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(12), .INST_WIDTH(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_ready = 0;

    mem_req_t mem_q[$];
    ref_req_t ref_pend[$];
    ref_ent_t ref_q[$];
    logic [11:0] ref_fpc = '0;
    int ref_gen = 0;

    int lat_min = 1, lat_max = 1, take_pct = 100, redir_pct = 0;
    logic force_redir = 1'b0;
    logic [11:0] force_pc = '0;

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        return {a, 7'h00} ^ {7'h00, a} ^ 19'h2A5C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Enters and leaves at a falling edge; one DUT clock per call.
    task automatic step();
        logic rd, tk, iv, exp_req;
        logic [11:0] rpc;
        logic [18:0] idata;
        ref_req_t p;
        int rdy;

        rd  = force_redir || ($urandom_range(99) < redir_pct);
        rpc = force_redir ? force_pc : 12'($urandom);
        tk  = ($urandom_range(99) < take_pct);
        iv  = 1'b0;
        idata = 19'($urandom);
        if (mem_q.size() != 0 && mem_q[0].ready <= cycle) begin
            iv    = 1'b1;
            idata = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        bus_if.redirect   = rd;
        bus_if.redirectPc = rpc;
        bus_if.take       = tk;
        bus_if.imValid    = iv;
        bus_if.imData     = idata;
        #1;

        exp_req = !rd && (ref_q.size() + ref_pend.size() < DEPTH);
        check_eq("imReq", 32'(bus_if.imReq), 32'(exp_req));
        if (exp_req) check_eq("imAddr", 32'(bus_if.imAddr), 32'(ref_fpc));
        check_eq("instValid", 32'(bus_if.instValid), 32'(ref_q.size() != 0));
        if (ref_q.size() != 0) begin
            check_eq("instruction", 32'(bus_if.instruction), 32'(ref_q[0].data));
            check_eq("pcOut", 32'(bus_if.pcOut), 32'(ref_q[0].pc1));
        end

        if (bus_if.imReq) begin
            rdy = cycle + int'($urandom_range(lat_max, lat_min));
            if (rdy <= last_ready) rdy = last_ready + 1;
            last_ready = rdy;
            mem_q.push_back('{bus_if.imAddr, rdy});
        end

        if (tk && ref_q.size() != 0 && !rd) void'(ref_q.pop_front());
        if (iv) begin
            check_eq("resp_has_request", 32'(ref_pend.size() != 0), 32'd1);
            if (ref_pend.size() != 0) begin
                p = ref_pend.pop_front();
                if (!rd && p.gen == ref_gen)
                    ref_q.push_back('{p.addr + 12'd1, mem_word(p.addr)});
            end
        end
        if (rd) begin
            ref_q.delete();
            ref_gen++;
            ref_fpc = rpc;
        end else if (exp_req) begin
            ref_pend.push_back('{ref_fpc, ref_gen});
            ref_fpc = ref_fpc + 12'd1;
        end

        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_imReq", 32'(bus_if.imReq), 32'd0);
        check_eq("rst_instValid", 32'(bus_if.instValid), 32'd0);
        check_eq("rst_instruction", 32'(bus_if.instruction), 32'd0);
        check_eq("rst_pcOut", 32'(bus_if.pcOut), 32'd0);
        @(posedge clk);
        cycle++;
        @(negedge clk);
        rst = 1'b0;
        mem_q.delete();
        ref_q.delete();
        ref_pend.delete();
        ref_fpc = '0;
        last_ready = cycle;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        bus_if.redirect = 1'b0;
        bus_if.redirectPc = '0;
        bus_if.take = 1'b0;
        bus_if.imValid = 1'b0;
        bus_if.imData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // L=1 streaming
        lat_min = 1; lat_max = 1; take_pct = 100; redir_pct = 0;
        run(20);

        // take held low, L=2: fill all slots, then drain
        do_reset();
        lat_min = 2; lat_max = 2; take_pct = 0;
        run(12);
        take_pct = 100;
        run(12);

        // L=3 with a redirect to 0x0A5 mid-flight
        lat_min = 3; lat_max = 3;
        run(4);
        force_redir = 1'b1; force_pc = 12'h0A5;
        step();
        force_redir = 1'b0;
        run(12);

        // PC wrap
        lat_min = 1; lat_max = 2;
        force_redir = 1'b1; force_pc = 12'hFFE;
        step();
        force_redir = 1'b0;
        run(12);

        // random mix
        lat_min = 1; lat_max = 4; take_pct = 70; redir_pct = 8;
        run(1500);

        // reset with requests in flight
        lat_min = 3; lat_max = 3; take_pct = 100; redir_pct = 0;
        for (int i = 0; i < 50 && ref_pend.size() < 3; i++) step();
        check_eq("pend_before_rst", 32'(ref_pend.size() >= 3), 32'd1);
        do_reset();
        lat_min = 1; lat_max = 3; take_pct = 60; redir_pct = 5;
        run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
